darkbus_dmem: RTL and testbench



---
 rtl/darkbus_pkg.sv | 13 +
 rtl/darkbus_ram.sv | 25 ++
 rtl/darkbus_dmem.sv | 168 ++++++++++++++++
 tb/tb_darkbus_dmem.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkbus_pkg.sv
// Shared constants for the darkbus data-side memory controller.
// State encodings, I/O window addresses and the window select bit.
package darkbus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] LED_ADDR  = 32'h8000_0000;
    localparam logic [31:0] CNT_ADDR  = 32'h8000_0004;
    localparam int unsigned IOWIN_BIT = 31;

endpackage

// File: rtl/darkbus_ram.sv
// WORDS x 32 on-chip RAM with per-byte write enables and a registered read port.
module darkbus_ram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_raddr,
    input  logic [AW-1:0] i_waddr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/darkbus_dmem.sv
// darkriscv data-port controller: wait-stated RAM access with HLT stall and sticky ERR.
// Optional I/O window (LED, cycle counter) enabled by defining DARKBUS_IOMAP_EN.
module darkbus_dmem
    import darkbus_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned WAIT  = 2
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_datao,
    input  logic [3:0]  i_be,
    input  logic        i_rd,
    input  logic        i_wr,
    output logic [31:0] o_datai,
    output logic        o_hlt,
    output logic        o_err,
    output logic [7:0]  o_led
);

    localparam int unsigned AW        = $clog2(WORDS);
    localparam int unsigned RAM_BYTES = 4 * WORDS;
    localparam int unsigned CW        = 4;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_store;
    logic          r_conflict;
    logic [31:0]   r_datai;
    logic          r_err;

    logic          w_req;
    logic          w_last;
    logic          w_capture;
    logic          w_commit;
    logic          w_ram_hit;
    logic          w_io_led;
    logic          w_io_cnt;
    logic          w_ok;
    logic [31:0]   w_rdata;
    logic [31:0]   w_ram_q;
    logic [3:0]    w_ram_we;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_io_q;

    assign w_req     = i_rd | i_wr;
    assign w_last    = (r_cnt == '0);
    assign w_capture = (r_state == ST_BUSY) && w_last;
    // Store lands on the edge the core retires the instruction; reset vetoes it.
    assign w_commit  = (r_state == ST_DONE) && r_store && !i_res;
    assign w_ram_hit = (r_addr < RAM_BYTES);
    assign w_ok      = (w_ram_hit || w_io_led || w_io_cnt) && !r_conflict;

    // Next-state and stall decode.
    always_comb begin
        w_state_nx = r_state;
        o_hlt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    o_hlt      = 1'b1;
                    w_state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_hlt = 1'b1;
                if (w_last) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_datai <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if ((r_state == ST_IDLE) && w_req) begin
                r_cnt <= CW'(WAIT - 1);
            end else if ((r_state == ST_BUSY) && !w_last) begin
                r_cnt <= r_cnt - CW'(1);
            end
            r_datai <= w_capture ? w_rdata : '0;
            if (w_capture && !w_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    // Request snapshot; the core holds it anyway, this decouples decode from the port.
    always_ff @(posedge i_clk) begin
        if ((r_state == ST_IDLE) && w_req) begin
            r_addr     <= i_daddr;
            r_wdata    <= i_datao;
            r_be       <= i_be;
            r_store    <= i_wr;
            r_conflict <= i_rd & i_wr;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (!r_store) begin
            if (w_ram_hit) begin
                w_rdata = w_ram_q;
            end else begin
                w_rdata = w_io_q;
            end
        end
    end

    assign w_raddr  = (r_state == ST_IDLE) ? i_daddr[AW+1:2] : r_addr[AW+1:2];
    assign w_ram_we = (w_commit && w_ram_hit) ? r_be : 4'b0000;

    darkbus_ram #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_raddr (w_raddr),
        .i_waddr (r_addr[AW+1:2]),
        .i_we    (w_ram_we),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

`ifdef DARKBUS_IOMAP_EN
    logic [7:0]  r_led;
    logic [31:0] r_cycles;

    assign w_io_led = r_addr[IOWIN_BIT] && (r_addr == LED_ADDR);
    assign w_io_cnt = r_addr[IOWIN_BIT] && (r_addr == CNT_ADDR);
    assign w_io_q   = w_io_led ? {24'h0, r_led} : (w_io_cnt ? r_cycles : 32'h0);
    assign o_led    = r_led;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_led    <= '0;
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_commit && w_io_led && r_be[0]) begin
                r_led <= r_wdata[7:0];
            end
        end
    end
`else
    assign w_io_led = 1'b0;
    assign w_io_cnt = 1'b0;
    assign w_io_q   = '0;
    assign o_led    = '0;
`endif

    assign o_datai = r_datai;
    assign o_err   = r_err;

endmodule

// File: tb/tb_darkbus_dmem.sv
// Scoreboard bench for darkbus_dmem (WAIT=2, WORDS=1024); I/O-window tests follow DARKBUS_IOMAP_EN.
module tb_darkbus_dmem;

    localparam int unsigned WORDS  = 1024;
    localparam int unsigned WAIT_C = 2;
    localparam int unsigned RAMB   = 4 * WORDS;

    typedef struct packed {
        logic        chk;
        logic [31:0] val;
    } sb_t;

    logic        clk = 1'b0;
    logic        i_res;
    logic [31:0] i_daddr;
    logic [31:0] i_datao;
    logic [3:0]  i_be;
    logic        i_rd;
    logic        i_wr;
    logic [31:0] o_datai;
    logic        o_hlt;
    logic        o_err;
    logic [7:0]  o_led;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    sb_t         exp_q[$];
    logic [31:0] model [int unsigned];
    logic [7:0]  model_led = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    darkbus_dmem #(.WORDS(WORDS), .WAIT(WAIT_C)) dut (
        .i_clk   (clk),
        .i_res   (i_res),
        .i_daddr (i_daddr),
        .i_datao (i_datao),
        .i_be    (i_be),
        .i_rd    (i_rd),
        .i_wr    (i_wr),
        .o_datai (o_datai),
        .o_hlt   (o_hlt),
        .o_err   (o_err),
        .o_led   (o_led)
    );

    function automatic sb_t expect_for(input logic wr, input logic [31:0] addr);
        sb_t e;
        e.chk = 1'b1;
        e.val = 32'h0;
        if (wr) e.val = 32'h0;
        else if (addr < RAMB) begin
            if (model.exists(addr >> 2)) e.val = model[addr >> 2];
            else e.chk = 1'b0;
        end
`ifdef DARKBUS_IOMAP_EN
        else if (addr == 32'h8000_0000) e.val = {24'h0, model_led};
        else if (addr == 32'h8000_0004) e.chk = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] w;
        if (addr < RAMB) begin
            w = model.exists(addr >> 2) ? model[addr >> 2] : 32'h0;
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
            model[addr >> 2] = w;
        end
`ifdef DARKBUS_IOMAP_EN
        else if (addr == 32'h8000_0000 && be[0]) model_led = data[7:0];
`endif
    endtask

    // One access: drive at the next edge, count stall cycles, check DATAI in DONE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input string name,
                          output logic [31:0] got, output int done_cyc);
        sb_t e;
        int  hc;
        bit  seen;
        exp_q.push_back(expect_for(wr, addr));
        @(posedge clk); #1;
        i_rd = rd; i_wr = wr; i_daddr = addr; i_datao = data; i_be = be;
        hc = 0; seen = 0; got = 32'h0; done_cyc = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (o_hlt === 1'b1) hc++;
            else seen = 1;
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout hlt stuck high for %0d cycles", name, hc);
        end else begin
            checks++;
            if (hc != int'(WAIT_C + 1)) begin
                errors++;
                $display("FAIL %s hlt_cycles got %0d want %0d", name, hc, WAIT_C + 1);
            end
            if (e.chk) begin
                checks++;
                if (o_datai !== e.val) begin
                    errors++;
                    $display("FAIL %s datai got %h want %h", name, o_datai, e.val);
                end
            end
            got = o_datai;
            done_cyc = cyc;
            if (wr) model_store(addr, data, be);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_rd = 1'b0; i_wr = 1'b0;
        end
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        i_res = 1'b1; i_rd = 1'b0; i_wr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_res = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks++;
        if (o_hlt !== 1'b0 || o_datai !== 32'h0 || o_err !== 1'b0 || o_led !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got hlt=%b datai=%h err=%b led=%h want 0/0/0/0",
                     o_hlt, o_datai, o_err, o_led);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] g;
        int          d;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, "store_full", g, d);
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, "load_full", g, d);
        checks++;
        if (g !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_full_const got %h want deadbeef", g);
        end
        idle(1);
        @(negedge clk);
        checks++;
        if (o_datai !== 32'h0) begin
            errors++;
            $display("FAIL datai_idle got %h want 0", o_datai);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] g;
        int          d;
        access(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b1111, "lane_init", g, d);
        access(1'b0, 1'b1, 32'h11, 32'h0000AB00, 4'b0010, "lane_store", g, d);
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, "lane_load", g, d);
        checks++;
        if (g !== 32'h1122AB44) begin
            errors++;
            $display("FAIL lane_merge got %h want 1122ab44", g);
        end
        access(1'b0, 1'b1, 32'h18, 32'hA5A5_0000, 4'b1100, "lane_hi", g, d);
        access(1'b1, 1'b0, 32'h18, 32'h0, 4'b1111, "lane_hi_load", g, d);
        idle(1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] g;
        int          d0;
        int          d1;
        int          extra;
        access(1'b0, 1'b1, 32'h00, 32'h0000_1111, 4'b1111, "b2b_init0", g, d0);
        access(1'b0, 1'b1, 32'h04, 32'h0000_2222, 4'b1111, "b2b_init1", g, d0);
        idle(1);
        access(1'b1, 1'b0, 32'h00, 32'h0, 4'b1111, "b2b_load0", g, d0);
        access(1'b1, 1'b0, 32'h04, 32'h0, 4'b1111, "b2b_load1", g, d1);
        checks++;
        if (d1 - d0 != int'(WAIT_C + 2)) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d", d1 - d0, WAIT_C + 2);
        end
        idle(1);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_hlt !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_no_extra got %0d stall cycles want 0", extra);
        end
    endtask

    task automatic test_miss;
        logic [31:0] g;
        int          d;
        access(1'b1, 1'b0, RAMB, 32'h0, 4'b1111, "miss_load", g, d);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL miss_err got %b want 1", o_err);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, "after_miss", g, d);
        idle(2);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", o_err);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] g;
        int          d;
        access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'b1111, "abort_init", g, d);
        idle(1);
        @(posedge clk); #1;
        i_wr = 1'b1; i_daddr = 32'h20; i_datao = 32'h55; i_be = 4'b1111;
        @(posedge clk); #1;
        i_res = 1'b1; i_wr = 1'b0;
        @(posedge clk); #1;
        i_res = 1'b0;
        @(negedge clk);
        checks++;
        if (o_hlt !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL res_busy got hlt=%b err=%b want 0/0", o_hlt, o_err);
        end
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, "res_busy_load", g, d);
        // Reset asserted inside the DONE cycle of a store must veto the write.
        @(posedge clk); #1;
        i_rd = 1'b0; i_wr = 1'b1; i_daddr = 32'h20; i_datao = 32'hCAFE_F00D; i_be = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_hlt === 1'b0) break;
        end
        i_res = 1'b1;
        @(posedge clk); #1;
        i_res = 1'b0; i_wr = 1'b0;
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, "res_done_load", g, d);
        idle(1);
    endtask

    task automatic test_iomap;
        logic [31:0] g;
        logic [31:0] c0;
        int          d;
`ifdef DARKBUS_IOMAP_EN
        access(1'b0, 1'b1, 32'h8000_0000, 32'h0000_005A, 4'b0001, "led_store", g, d);
        idle(1);
        @(negedge clk);
        checks++;
        if (o_led !== 8'h5A) begin
            errors++;
            $display("FAIL led_value got %h want 5a", o_led);
        end
        access(1'b0, 1'b1, 32'h8000_0000, 32'h0000_00FF, 4'b1110, "led_be0_off", g, d);
        access(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b1111, "led_load", g, d);
        access(1'b0, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'b1111, "cnt_store", g, d);
        access(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'b1111, "cnt_load0", c0, d);
        access(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'b1111, "cnt_load1", g, d);
        checks++;
        if (g - c0 !== 32'(WAIT_C + 2)) begin
            errors++;
            $display("FAIL cnt_delta got %0d want %0d", g - c0, WAIT_C + 2);
        end
        idle(1);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0 || o_led !== 8'h5A) begin
            errors++;
            $display("FAIL io_no_err got err=%b led=%h want 0/5a", o_err, o_led);
        end
`else
        c0 = 32'h0;
        access(1'b0, 1'b1, 32'h8000_0000, 32'h0000_005A, 4'b0001, "io_off_store", g, d);
        access(1'b1, 1'b0, 32'h8000_0000, c0, 4'b1111, "io_off_load", g, d);
        idle(1);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || o_led !== 8'h00) begin
            errors++;
            $display("FAIL io_off got err=%b led=%h want 1/00", o_err, o_led);
        end
        do_reset();
`endif
    endtask

    task automatic test_conflict;
        logic [31:0] g;
        int          d;
        access(1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, 4'b1111, "rdwr_store", g, d);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL rdwr_err got %b want 1", o_err);
        end
        access(1'b1, 1'b0, 32'h30, 32'h0, 4'b1111, "rdwr_load", g, d);
        idle(1);
    endtask

    initial begin
        i_res = 1'b1; i_rd = 1'b0; i_wr = 1'b0;
        i_daddr = 32'h0; i_datao = 32'h0; i_be = 4'h0;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_back_to_back();
        test_miss();
        test_reset_abort();
        test_iomap();
        test_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
